pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Each cycle it decides which pipeline registers advance, freeze or are loaded with a bubble. Inputs it arbitrates:
- load-use hazards between ID and EX;
- taken branches/jumps resolved in EX;
- fixed-latency multiply/divide operations that freeze the front of the pipe.

It sits beside the hazard detection logic and drives the PC, IF/ID and ID/EX register enables.

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/pipeline_stall_controller_load_use_detect.sv | 18 +
 rtl/pipeline_stall_controller.sv | 135 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// controller state encodings, the hard-wired zero register and the default
// multiply/divide occupancy of EX.
package pipeline_ctrl_pkg;

    typedef logic [0:0] ctrl_state_t;

    localparam ctrl_state_t RUN     = 1'b0;
    localparam ctrl_state_t MD_WAIT = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int MD_LATENCY_DEF = 4;

endpackage

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Load-use hazard detection between ID and EX. Purely combinational.
// A load writing r0 never creates a hazard because r0 always reads as zero.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu
);

    assign lu = ex_mem_read
              && (ex_rd != REG_ZERO)
              && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Drives the PC,
// IF/ID and ID/EX enables from the hazard, branch and mult/div inputs.
// Performance counters are only built when STALL_PERF_EN is defined;
// otherwise stall_cycles and flush_count read as zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; branch flush, mult/div start or load-use bubble
// MD_WAIT | mult/div occupies EX; front of pipe frozen until md_cnt==0
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // The RUN cycle of a mult/div counts as the first freeze cycle and the
    // MD_WAIT cycle with md_cnt==0 as the last, hence the -2.
    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);

    ctrl_state_t state, state_nxt;
    logic [3:0]  md_cnt, md_cnt_nxt;
    logic        lu;

    load_use_detect u_lu (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (lu)
    );

    // Enables and next state from current state and the prioritised events.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        md_busy     = 1'b0;
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (ex_md_start) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_we    = 1'b0;
                    md_busy    = 1'b1;
                    md_cnt_nxt = MD_INIT;
                    state_nxt  = MD_WAIT;
                end else if (lu) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MD_WAIT: begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                idex_we = 1'b0;
                md_busy = 1'b1;
                if (md_cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    md_cnt_nxt = md_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt  = RUN;
                md_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State and mult/div countdown registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Free-running wrap-around counters of frozen-PC cycles and branch flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_we) begin
                stall_q <= stall_q + 1'b1;
            end
            if (ifid_flush) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MD_LATENCY=4).
// Control outputs are compared as {pc_we, ifid_we, ifid_flush, idex_we,
// idex_bubble, md_busy}.
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_mem_read, ex_branch_taken, ex_md_start;
    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, md_busy;
    logic [31:0] stall_cycles, flush_count;

    int n_total = 0;
    int n_bad   = 0;
    int e_stall = 0;
    int e_flush = 0;

    localparam logic [5:0] IDLE   = 6'b110100;
    localparam logic [5:0] LU     = 6'b000110;
    localparam logic [5:0] FREEZE = 6'b000001;
    localparam logic [5:0] FLUSH  = 6'b111110;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MD_LATENCY(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_we         (idex_we),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check control outputs, then check
    // counters after the rising edge.
    task automatic step(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] rd, input logic mr,
                        input logic bt, input logic md, input logic [5:0] exp);
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rd = rd;
        ex_mem_read = mr; ex_branch_taken = bt; ex_md_start = md;
        #1;
        chk({tag, " ctl"}, {26'd0, pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, md_busy},
            {26'd0, exp});
        if (!exp[5]) e_stall++;
        if (exp[3])  e_flush++;
        @(posedge clk);
        #1;
        if (rst_n == 1'b0) begin
            e_stall = 0;
            e_flush = 0;
        end
`ifdef STALL_PERF_EN
        chk({tag, " stall_cycles"}, stall_cycles, 32'(e_stall));
        chk({tag, " flush_count"},  flush_count,  32'(e_flush));
`else
        chk({tag, " stall_cycles"}, stall_cycles, 32'd0);
        chk({tag, " flush_count"},  flush_count,  32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
        repeat (2) @(posedge clk);
        step("reset",      5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);
        rst_n = 1'b1;

        step("idle",       5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);
        step("lu_rs",      5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, LU);
        step("lu_after",   5'd4, 5'd5, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, IDLE);
        step("lu_rt",      5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, LU);
        step("rt_unused",  5'd3, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, IDLE);
        step("zero_reg",   5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, IDLE);
        step("not_load",   5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, IDLE);
        step("lu_b2b_1",   5'd6, 5'd1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, LU);
        step("lu_b2b_2",   5'd2, 5'd10, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, LU);

        step("md_start",   5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, FREEZE);
        step("md_w1",      5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        step("md_w2_br",   5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, FREEZE);
        step("md_w3_lu",   5'd3, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, FREEZE);
        step("md_done",    5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);

        step("br_lu",      5'd8, 5'd2, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, FLUSH);
        step("br_md",      5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, FLUSH);
        step("post_br",    5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);

        step("md2_start",  5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, FREEZE);
        step("md2_w1",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        step("md2_w2",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        step("md2_w3",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        step("md3_start",  5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, FREEZE);
        step("md3_w1",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        step("md3_w2",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        step("md3_w3",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        step("md3_done",   5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);

        step("md4_start",  5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, FREEZE);
        step("md4_w1",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        rst_n = 1'b0;
        step("md4_w2_rst", 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, FREEZE);
        rst_n = 1'b1;
        step("post_rst",   5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);
        step("post_rst_lu",5'd5, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, LU);
        step("final",      5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, IDLE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
